// File: rtl/ysyx_22041461_dmem_resp.sv
// Data-side memory responder: word-addressed 64-bit array behind a valid/ready
// request/response pair, one outstanding transaction, fixed programmable latency.
module ysyx_22041461_dmem_resp #(
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_mask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [63:0] LAST  = BASE + 64'(DEPTH) * 64'd8 - 64'd1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              accept, access;
  logic [63:0]       addr_q, wdata_q;
  logic              wen_q, in_range_q;
  logic [7:0]        mask_q;
  logic [ADDR_W-1:0] idx;
  logic [63:0]       mem [DEPTH];

  assign req_ready = (state == IDLE) && !rst;
  assign idx       = ADDR_W'((addr_q - BASE) >> 3);

  // Next-state and access strobes
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      mask_q     <= '0;
      in_range_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        wen_q      <= req_wen;
        mask_q     <= req_mask;
        in_range_q <= (req_addr >= BASE) && (req_addr <= LAST);
      end
      if (access) begin
        resp_valid <= 1'b1;
        resp_err   <= !in_range_q;
        resp_rdata <= (in_range_q && !wen_q) ? mem[idx] : 64'h0;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Array is not reset; reset forces IDLE so a pending write never commits
  always_ff @(posedge clk) begin
    if (access && wen_q && in_range_q) begin
      for (int i = 0; i < 8; i++) begin
        if (mask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
